// File: rtl/rename_map_table_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_map_table_pkg : shared defaults and types for the map table |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rename_map_table_pkg;

  localparam int NUM_AREGS_DEF = 32;
  localparam int TAG_W_DEF     = 8;
  localparam int NUM_PORTS_DEF = 2;
  localparam int NUM_CDB_DEF   = 2;
  localparam int NUM_CKPT_DEF  = 4;

  typedef logic [TAG_W_DEF-1:0]              tag_t;
  typedef logic [$clog2(NUM_AREGS_DEF)-1:0]  areg_t;

  // Tag 0 means the value lives in the architectural register file.
  localparam tag_t TAG_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/map_ckpt_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | map_ckpt_fifo : circular FIFO of map-table snapshots with CDB      |
// | ready tracking in live slots.  Rev 1.0                             |
// +--------------------------------------------------------------------+
module map_ckpt_fifo
  import rename_map_table_pkg::*;
#(
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF,
  parameter int NUM_CKPT  = NUM_CKPT_DEF,
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            take_i,
  input  logic                            release_i,
  input  logic                            restore_i,
  input  logic [CKPT_W-1:0]               restore_id_i,
  input  logic [NUM_AREGS-1:0][TAG_W-1:0] snap_tag_i,
  input  logic [NUM_AREGS-1:0]            snap_rdy_i,
  input  logic [NUM_CDB-1:0]              cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]        cdb_tag_i,
  output logic [NUM_AREGS-1:0][TAG_W-1:0] restore_tag_o,
  output logic [NUM_AREGS-1:0]            restore_rdy_o,
  output logic [CKPT_W-1:0]               id_o,
  output logic                            full_o
);

  localparam logic [CKPT_W:0] FULL_CNT = (CKPT_W+1)'(NUM_CKPT);

  logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CKPT_W:0]   count_q, count_d;
  logic              take_ok, rel_ok;

  logic [NUM_AREGS-1:0][TAG_W-1:0] slot_tag_q [NUM_CKPT];
  logic [NUM_AREGS-1:0]            slot_rdy_q [NUM_CKPT];
  logic [NUM_AREGS-1:0]            slot_hit   [NUM_CKPT];
  logic [NUM_CKPT-1:0]             slot_live;

  function automatic logic [CKPT_W-1:0] ptr_inc(input logic [CKPT_W-1:0] p);
    return (p == CKPT_W'(NUM_CKPT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Distance from base to p walking forward around the ring.
  function automatic logic [CKPT_W:0] ptr_dist(input logic [CKPT_W-1:0] p,
                                               input logic [CKPT_W-1:0] base);
    return (p >= base) ? ({1'b0, p} - {1'b0, base})
                       : ({1'b0, p} + FULL_CNT - {1'b0, base});
  endfunction

  always_comb begin : slot_cdb
    for (int s = 0; s < NUM_CKPT; s++) begin
      slot_live[s] = ptr_dist(CKPT_W'(s), head_q) < count_q;
      for (int r = 0; r < NUM_AREGS; r++) begin
        slot_hit[s][r] = 1'b0;
        for (int c = 0; c < NUM_CDB; c++) begin
          if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == slot_tag_q[s][r])) begin
            slot_hit[s][r] = 1'b1;
          end
        end
      end
    end
  end

  assign restore_tag_o = slot_tag_q[restore_id_i];
  assign restore_rdy_o = slot_rdy_q[restore_id_i] | slot_hit[restore_id_i];
  assign id_o          = tail_q;
  assign full_o        = (count_q == FULL_CNT);

  always_comb begin : ptr_next
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    take_ok = take_i && !restore_i && (count_q != FULL_CNT);
    rel_ok  = release_i && (count_q != '0);
    if (restore_i) begin
      // Everything younger than the restored slot is discarded.
      tail_d  = ptr_inc(restore_id_i);
      count_d = ptr_dist(restore_id_i, head_q) + 1'b1;
    end else if (take_ok) begin
      tail_d  = ptr_inc(tail_q);
      count_d = count_q + 1'b1;
    end
    if (rel_ok) begin
      head_d  = ptr_inc(head_q);
      count_d = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (slot_live[s]) begin
        slot_rdy_q[s] <= slot_rdy_q[s] | slot_hit[s];
      end
    end
    if (take_ok) begin
      slot_tag_q[tail_q] <= snap_tag_i;
      slot_rdy_q[tail_q] <= snap_rdy_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_map_table : register rename map with intra-group bypass,    |
// | CDB wakeup and optional checkpoints (RENAME_MAP_CKPT_EN). Rev 1.0  |
// +--------------------------------------------------------------------+
module rename_map_table
  import rename_map_table_pkg::*;
#(
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF,
  parameter int NUM_CKPT  = NUM_CKPT_DEF,
  localparam int AREG_W   = $clog2(NUM_AREGS),
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        disp_valid_i,
  input  logic [NUM_PORTS*AREG_W-1:0] disp_src1_areg_i,
  input  logic [NUM_PORTS*AREG_W-1:0] disp_src2_areg_i,
  input  logic [NUM_PORTS*AREG_W-1:0] disp_dest_areg_i,
  input  logic [NUM_PORTS*TAG_W-1:0]  disp_dest_tag_i,
  output logic [NUM_PORTS*TAG_W-1:0]  src1_tag_o,
  output logic [NUM_PORTS*TAG_W-1:0]  src2_tag_o,
  output logic [NUM_PORTS-1:0]        src1_ready_o,
  output logic [NUM_PORTS-1:0]        src2_ready_o,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i,
  input  logic                        ckpt_take_i,
  output logic [CKPT_W-1:0]           ckpt_id_o,
  output logic                        ckpt_full_o,
  input  logic                        ckpt_release_i,
  input  logic                        ckpt_restore_i,
  input  logic [CKPT_W-1:0]           ckpt_restore_id_i
);

  logic [NUM_AREGS-1:0][TAG_W-1:0] map_tag_q, map_tag_d, upd_tag, ckpt_tag;
  logic [NUM_AREGS-1:0]            map_rdy_q, map_rdy_d, upd_rdy, ckpt_rdy;
  logic                            restore_act;

  always_comb begin : src_lookup
    logic [AREG_W-1:0] a;
    logic [TAG_W-1:0]  t;
    logic              r;
    src1_tag_o   = '0;
    src2_tag_o   = '0;
    src1_ready_o = '0;
    src2_ready_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int s = 0; s < 2; s++) begin
        a = (s == 0) ? disp_src1_areg_i[i*AREG_W +: AREG_W]
                     : disp_src2_areg_i[i*AREG_W +: AREG_W];
        t = map_tag_q[a];
        r = map_rdy_q[a];
        for (int c = 0; c < NUM_CDB; c++) begin
          if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == t)) begin
            r = 1'b1;
          end
        end
        // Older lanes in the same group override the table; ascending scan leaves the youngest.
        for (int j = 0; j < NUM_PORTS; j++) begin
          if ((j < i) && disp_valid_i[j] && (disp_dest_areg_i[j*AREG_W +: AREG_W] == a)) begin
            t = disp_dest_tag_i[j*TAG_W +: TAG_W];
            r = 1'b0;
          end
        end
        if (a == '0) begin
          t = TAG_W'(TAG_NONE);
          r = 1'b1;
        end
        if (s == 0) begin
          src1_tag_o[i*TAG_W +: TAG_W] = t;
          src1_ready_o[i]              = r;
        end else begin
          src2_tag_o[i*TAG_W +: TAG_W] = t;
          src2_ready_o[i]              = r;
        end
      end
    end
  end

  always_comb begin : table_next
    upd_tag = map_tag_q;
    upd_rdy = map_rdy_q;
    for (int r = 0; r < NUM_AREGS; r++) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == map_tag_q[r])) begin
          upd_rdy[r] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (disp_valid_i[i] && (disp_dest_areg_i[i*AREG_W +: AREG_W] != '0)) begin
        upd_tag[disp_dest_areg_i[i*AREG_W +: AREG_W]] = disp_dest_tag_i[i*TAG_W +: TAG_W];
        upd_rdy[disp_dest_areg_i[i*AREG_W +: AREG_W]] = 1'b0;
      end
    end
    if (restore_act) begin
      map_tag_d = ckpt_tag;
      map_rdy_d = ckpt_rdy;
    end else begin
      map_tag_d = upd_tag;
      map_rdy_d = upd_rdy;
    end
    map_tag_d[0] = TAG_W'(TAG_NONE);
    map_rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_tag_q <= {NUM_AREGS{TAG_W'(TAG_NONE)}};
      map_rdy_q <= '1;
    end else begin
      map_tag_q <= map_tag_d;
      map_rdy_q <= map_rdy_d;
    end
  end

`ifdef RENAME_MAP_CKPT_EN
  map_ckpt_fifo #(
    .NUM_AREGS (NUM_AREGS),
    .TAG_W     (TAG_W),
    .NUM_CDB   (NUM_CDB),
    .NUM_CKPT  (NUM_CKPT)
  ) u_ckpt_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .take_i        (ckpt_take_i),
    .release_i     (ckpt_release_i),
    .restore_i     (ckpt_restore_i),
    .restore_id_i  (ckpt_restore_id_i),
    .snap_tag_i    (upd_tag),
    .snap_rdy_i    (upd_rdy),
    .cdb_valid_i   (cdb_valid_i),
    .cdb_tag_i     (cdb_tag_i),
    .restore_tag_o (ckpt_tag),
    .restore_rdy_o (ckpt_rdy),
    .id_o          (ckpt_id_o),
    .full_o        (ckpt_full_o)
  );
  assign restore_act = ckpt_restore_i;
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_take_i, ckpt_release_i, ckpt_restore_i, ckpt_restore_id_i};
  assign restore_act = 1'b0;
  assign ckpt_tag    = '0;
  assign ckpt_rdy    = '0;
  assign ckpt_id_o   = '0;
  assign ckpt_full_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rename_map_table.md
RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 Parameter NUM_AREGS, 32, architectural registers; AREG_W = clog2(NUM_AREGS).
REQ-002 Parameter TAG_W, 8, rename tag width; tag 0 means "value in architectural file".
REQ-003 Parameter NUM_PORTS, 2, rename lanes per cycle; lane 0 is oldest.
REQ-004 Parameter NUM_CDB, 2, result broadcast buses.
REQ-005 Parameter NUM_CKPT, 4, checkpoint slots; CKPT_W = clog2(NUM_CKPT).
REQ-006 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-007 Port: reset  in  1  asynchronous, active-low reset.
REQ-008 Ports: disp_valid in NUM_PORTS; disp_src1_areg, disp_src2_areg, disp_dest_areg in NUM_PORTS*AREG_W; disp_dest_tag in NUM_PORTS*TAG_W; lane i uses slice i.
REQ-009 Ports: src1_tag, src2_tag out NUM_PORTS*TAG_W; src1_ready, src2_ready out NUM_PORTS; combinational lookup.
REQ-010 Ports: cdb_valid in NUM_CDB; cdb_tag in NUM_CDB*TAG_W.
REQ-011 Ports: ckpt_take in 1; ckpt_id out CKPT_W; ckpt_full out 1; ckpt_release in 1; ckpt_restore in 1; ckpt_restore_id in CKPT_W.

Function
REQ-012 Each entry SHALL hold tag[TAG_W] and ready bit; read of areg r returns entry r's tag/ready.
REQ-013 Lane i source lookup SHALL bypass from the youngest lane j<i with disp_valid[j] and matching dest: tag = disp_dest_tag[j], ready = 0.
REQ-014 Absent bypass, a source whose entry tag matches a valid cdb_tag this cycle SHALL read ready = 1 (same-cycle CDB forward).
REQ-015 On edge, each valid lane SHALL write dest_tag, ready = 0; on duplicate dest the highest-index lane wins.
REQ-016 Writes to areg 0 SHALL be ignored; areg 0 SHALL always read tag 0, ready 1.
REQ-017 CDB match SHALL set ready = 1 in live table and every allocated checkpoint; a same-cycle dispatch write to that entry overrides (ready = 0).
REQ-018 Checkpoints SHALL form a circular FIFO (head, tail, count); ckpt_full = (count == NUM_CKPT); ckpt_id = tail.
REQ-019 ckpt_take SHALL store the table after this cycle's writes and CDB updates into slot tail, tail++ with wrap; taken when full SHALL be ignored.
REQ-020 ckpt_release SHALL free slot head, head++; ignored when count == 0; take+release same cycle SHALL leave count unchanged.
REQ-021 ckpt_restore SHALL, next edge, load table from slot ckpt_restore_id, then apply this cycle's CDB set-ready, set tail = ckpt_restore_id+1 (wrap), discard younger slots.
REQ-022 Restore SHALL take priority over same-cycle dispatch writes and ckpt_take (both dropped); concurrent ckpt_release SHALL still apply.
REQ-023 Restore of an unallocated id is a protocol error; bench SHALL flag it, RTL behaviour unspecified.

Reset
REQ-024 On reset low, asynchronously: all entries tag 0 ready 1; head = tail = count = 0; ckpt_full = 0, ckpt_id = 0; checkpoint contents don't-care.
REQ-025 Reset asserted mid-restore or mid-take SHALL override all; first edge after deassertion uses reset state.

Configuration
REQ-026 Macro RENAME_MAP_CKPT_EN: defined -> checkpoint logic per REQ-018..023; undefined -> no checkpoint storage, ckpt_take/release/restore ignored, ckpt_full and ckpt_id tied 0.

Structure
REQ-027 Shared package SHALL hold default parameter values, tag_t/areg_t typedefs, constant TAG_NONE = 0.
REQ-028 One sub-module map_ckpt_fifo SHALL own pointers, count, slot storage and slot CDB updates.

Verification
REQ-029 Reset then read src1 areg 5 -> tag 0, ready 1; all checkpoint flags 0.
REQ-030 Lane0 dest r3 tag 0x11, lane1 src1 r3 same cycle -> lane1 src1_tag 0x11, ready 0; next cycle r3 reads 0x11/0.
REQ-031 Both lanes dest r7 (0x20, 0x21) -> r7 = 0x21; cdb 0x21 next cycle -> r7 ready 1; cdb 0x20 -> no change.
REQ-032 r4 = 0x30 pending, ckpt_take (id 0), then r4 <- 0x31, cdb 0x30, restore id 0 -> r4 = 0x30 ready 1; tail = 1.
REQ-033 Four takes -> ckpt_full = 1; fifth take ignored; release -> full 0, head 1; take -> slot 0 reused (wrap).
REQ-034 Restore with dispatch lane0 dest r9 same cycle -> r9 unchanged from checkpoint; with macro undefined restore is no-op.
